// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: APB master that runs one ECC_ENC_DEC job at a time.
// Writes DATA_IN/CODEWORD_WIDTH/NOISE/CTRL, waits for done, returns result.
module ecc_apb_sequencer #(
  parameter int          DATA_WIDTH      = 32,
  parameter int          AMBA_ADDR_WIDTH = 20,
  parameter int          AMBA_WORD       = 32,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int          TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [DATA_WIDTH-1:0]      req_data,
  input  logic [1:0]                 req_width,
  input  logic [DATA_WIDTH-1:0]      req_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_errors,
  output logic                       rsp_timeout,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PENABLE,
  output logic                       PSEL,
  output logic                       PWRITE,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  output logic                       busy
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [AMBA_ADDR_WIDTH-1:0] BASE = AMBA_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_CTRL = AMBA_ADDR_WIDTH'(0);
  localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_DIN = AMBA_ADDR_WIDTH'(4);
  localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_WID = AMBA_ADDR_WIDTH'(8);
  localparam logic [AMBA_ADDR_WIDTH-1:0] OFF_NOI = AMBA_ADDR_WIDTH'(12);

  // write-list entries in issue order
  localparam logic [1:0] E_DIN  = 2'd0;
  localparam logic [1:0] E_WID  = 2'd1;
  localparam logic [1:0] E_NOI  = 2'd2;
  localparam logic [1:0] E_CTRL = 2'd3;

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, WAIT_DONE, RESP
  } state_e;

  state_e                      state_q;
  logic [1:0]                  idx_q;
  logic [1:0]                  op_q;
  logic [DATA_WIDTH-1:0]       data_q;
  logic [1:0]                  width_q;
  logic [DATA_WIDTH-1:0]       noise_q;
  logic                        shadow_vld_q;
  logic [1:0]                  shadow_q;
  logic [CW-1:0]               cnt_q;
  logic                        req_ready_q;
  logic                        rsp_valid_q;
  logic [DATA_WIDTH-1:0]       rsp_data_q;
  logic [1:0]                  rsp_nerr_q;
  logic                        rsp_to_q;
  logic [AMBA_ADDR_WIDTH-1:0]  paddr_q;
  logic [AMBA_WORD-1:0]        pwdata_q;
  logic                        psel_q;
  logic                        penable_q;
  logic                        busy_q;
  logic [1:0]                  idx_d;
  logic                        skip_wid;

  function automatic logic [AMBA_ADDR_WIDTH-1:0] ent_addr(
    input logic [1:0] i
  );
    logic [AMBA_ADDR_WIDTH-1:0] r;
    r = BASE + OFF_CTRL;
    unique case (i)
      E_DIN:   r = BASE + OFF_DIN;
      E_WID:   r = BASE + OFF_WID;
      E_NOI:   r = BASE + OFF_NOI;
      default: r = BASE + OFF_CTRL;
    endcase
    return r;
  endfunction

  function automatic logic [AMBA_WORD-1:0] ent_data(
    input logic [1:0]            i,
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] d,
    input logic [1:0]            w,
    input logic [DATA_WIDTH-1:0] n
  );
    logic [AMBA_WORD-1:0] r;
    r = '0;
    unique case (i)
      E_DIN:   r = AMBA_WORD'(d);
      E_WID:   r = AMBA_WORD'(w);
      E_NOI:   r = AMBA_WORD'(n);
      default: r = AMBA_WORD'(op);
    endcase
    return r;
  endfunction

  // pick the entry that follows the current one, dropping a redundant width write
  always_comb begin
    skip_wid = shadow_vld_q && (shadow_q == width_q);
    idx_d    = E_CTRL;
    unique case (idx_q)
      E_DIN:   idx_d = skip_wid ? E_NOI : E_WID;
      E_WID:   idx_d = E_NOI;
      E_NOI:   idx_d = E_CTRL;
      default: idx_d = E_CTRL;
    endcase
  end

  // sequencer FSM with registered APB and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= E_DIN;
      op_q         <= '0;
      data_q       <= '0;
      width_q      <= '0;
      noise_q      <= '0;
      shadow_vld_q <= 1'b0;
      shadow_q     <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_nerr_q   <= '0;
      rsp_to_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            data_q      <= req_data;
            width_q     <= req_width;
            noise_q     <= req_noise;
            idx_q       <= E_DIN;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            paddr_q     <= ent_addr(E_DIN);
            pwdata_q    <= ent_data(E_DIN, req_op, req_data,
                                    req_width, req_noise);
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (idx_q == E_WID) begin
            shadow_q     <= width_q;
            shadow_vld_q <= 1'b1;
          end
          if (idx_q == E_CTRL) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= WAIT_DONE;
          end else begin
            idx_q     <= idx_d;
            penable_q <= 1'b0;
            paddr_q   <= ent_addr(idx_d);
            pwdata_q  <= ent_data(idx_d, op_q, data_q, width_q, noise_q);
            state_q   <= SETUP;
          end
        end
        WAIT_DONE: begin
          if (operation_done) begin
            rsp_data_q  <= data_out;
            rsp_nerr_q  <= num_of_errors;
            rsp_to_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q   <= '0;
            rsp_nerr_q   <= '0;
            rsp_to_q     <= 1'b1;
            rsp_valid_q  <= 1'b1;
            shadow_vld_q <= 1'b0;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_num_errors = rsp_nerr_q;
  assign rsp_timeout    = rsp_to_q;
  assign PADDR          = paddr_q;
  assign PWDATA         = pwdata_q;
  assign PSEL           = psel_q;
  assign PENABLE        = penable_q;
  assign PWRITE         = psel_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: random jobs against a write-list/ECC reference model.
// The bench plays the ECC slave: it observes APB writes and drives done.
module tb_ecc_apb_sequencer;

  localparam int DW   = 32;
  localparam int AW   = 20;
  localparam int WW   = 32;
  localparam int T    = 64;
  localparam int BASE = 'h300;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  logic [1:0]    req_width;
  logic [DW-1:0] req_noise;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_num_errors;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [WW-1:0] PWDATA;
  logic          PENABLE;
  logic          PSEL;
  logic          PWRITE;
  logic [DW-1:0] data_out;
  logic          operation_done;
  logic [1:0]    num_of_errors;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state: what the ECC block last saw as width
  bit         sh_v;
  logic [1:0] sh_w;

  ecc_apb_sequencer #(
    .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW),
    .BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .req_width(req_width), .req_noise(req_noise),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_num_errors(rsp_num_errors),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL(PSEL), .PWRITE(PWRITE),
    .data_out(data_out), .operation_done(operation_done),
    .num_of_errors(num_of_errors), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // dly: 0 = ECC never answers, else done driven in wait cycle dly
  task automatic run_job(input logic [1:0] op, input logic [DW-1:0] d,
                         input logic [1:0] w, input logic [DW-1:0] nz,
                         input int dly, input logic [DW-1:0] dout,
                         input logic [1:0] ne, input int hold,
                         input bit spur, input bit abort);
    logic [AW-1:0] a[$];
    logic [WW-1:0] v[$];
    int            widx;
    int            got;
    int            exp_w;
    logic [DW-1:0] ed;
    logic [1:0]    ene;
    logic          eto;
    widx = -1;
    a.push_back(AW'(BASE + 4)); v.push_back(d);
    if (!(sh_v && sh_w == w)) begin
      widx = a.size();
      a.push_back(AW'(BASE + 8)); v.push_back({30'b0, w});
    end
    a.push_back(AW'(BASE + 12)); v.push_back(nz);
    a.push_back(AW'(BASE));      v.push_back({30'b0, op});

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_data = d;
    req_width = w; req_noise = nz;
    @(negedge clk);
    req_valid = 0; req_op = 2'($urandom);
    req_data = $urandom; req_width = 2'($urandom); req_noise = $urandom;

    for (int k = 0; k < a.size(); k++) begin
      chk("apb_setup",
          {PSEL, PENABLE, PWRITE, busy, req_ready, PADDR, PWDATA},
          {5'b10110, a[k], v[k]});
      if (spur && k == 0) begin
        operation_done = 1; num_of_errors = 2; data_out = $urandom;
      end
      @(negedge clk);
      operation_done = 0;
      chk("apb_access",
          {PSEL, PENABLE, PWRITE, busy, req_ready, PADDR, PWDATA},
          {5'b11110, a[k], v[k]});
      if (k == widx) begin sh_v = 1; sh_w = w; end
      if (abort && k == a.size() - 2) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        sh_v = 0;
        chk("rst_mid", {PSEL, PENABLE, req_ready, rsp_valid, busy},
            5'b00100);
        return;
      end
      @(negedge clk);
    end

    chk("wait_entry", {PSEL, PENABLE, busy, rsp_valid, req_ready},
        5'b00100);
    got = 0;
    for (int c = 1; c <= T + 10; c++) begin
      if (rsp_valid) begin got = c; break; end
      if (c == dly) begin
        operation_done = 1; data_out = dout; num_of_errors = ne;
      end
      @(negedge clk);
      operation_done = 0;
      data_out = $urandom; num_of_errors = 2'($urandom);
    end
    if (dly > 0 && dly <= T) begin
      exp_w = dly + 1; ed = dout; ene = ne; eto = 0;
    end else begin
      exp_w = T + 1; ed = '0; ene = '0; eto = 1; sh_v = 0;
    end
    chk("rsp_latency", 64'(got), 64'(exp_w));

    for (int h = 0; h <= hold; h++) begin
      chk("rsp_hold",
          {rsp_valid, req_ready, busy, rsp_timeout, rsp_num_errors, rsp_data},
          {3'b101, eto, ene, ed});
      rsp_ready = (h == hold);
      req_valid = (h < hold) ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    rsp_ready = 0;
    req_valid = 0;
    chk("rsp_done", {rsp_valid, req_ready, busy, PSEL}, 4'b0100);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_op = 0; req_data = 0; req_width = 0;
    req_noise = 0; rsp_ready = 0; data_out = 0; operation_done = 0;
    num_of_errors = 0;
    sh_v = 0; sh_w = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctl",
        {req_ready, rsp_valid, rsp_timeout, rsp_num_errors, PSEL,
         PENABLE, PWRITE, busy, rsp_data},
        {1'b1, 40'b0});
    chk("reset_apb", {PADDR, PWDATA}, '0);
    rst = 0;
    @(negedge clk);

    run_job(0, 'hA5, 0, 0, 3, 'h5A, 0, 0, 0, 0);
    run_job(0, 'h11, 0, 'h3, 2, 'h22, 1, 0, 0, 0);
    run_job(1, 'h33, 2, 'h80, 1, 'h44, 1, 0, 0, 0);
    run_job(1, 'h55, 2, 'h01, 0, 'h66, 2, 0, 0, 0);
    run_job(2, 'h77, 2, 'h0, 4, 'h88, 0, 10, 0, 0);
    run_job(0, 'h99, 1, 'h5, 2, 'hAA, 0, 0, 0, 1);
    run_job(0, 'hBB, 1, 'h5, 5, 'hCC, 1, 1, 1, 0);
    run_job(3, 'hDD, 1, 'h7, T, 'hEE, 3, 0, 0, 0);
    run_job(2, 'hFF, 1, 'h9, T - 1, 'h12, 2, 0, 0, 0);

    for (int j = 0; j < 40; j++) begin
      int r;
      int dl;
      r  = $urandom_range(0, 9);
      dl = (r == 9) ? T : r;
      run_job(2'($urandom), $urandom, 2'($urandom_range(0, 2)), $urandom,
              dl, $urandom, 2'($urandom), $urandom_range(0, 3),
              1'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ecc_apb_sequencer.md
Name: ecc_apb_sequencer

Overview:
APB master controller that sequences one ECC encoder/decoder job at a time on behalf of a single requester.
- Accepts a job (operation, data, codeword width, noise) on a valid/ready request port.
- Programs the ECC_ENC_DEC register file over APB, with the CTRL write last so that it starts the operation.
- Waits for operation_done, then returns data_out and num_of_errors on a valid/ready response port, with a watchdog timeout.
- Sits between the test/system requester and the ECC_ENC_DEC APB slave port.

Parameters:
- DATA_WIDTH, 32, width of job data, noise and data_out.
- AMBA_ADDR_WIDTH, 20, PADDR width.
- AMBA_WORD, 32, PWDATA width.
- BASE_ADDR, 0, base address of the ECC register block; offsets are added to it.
- TIMEOUT_CYCLES, 64, maximum WAIT_DONE cycles before the job is aborted; must be >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  job request valid.
- req_ready  out  1  job accepted when req_valid & req_ready.
- req_op  in  2  CTRL operation: 0 encode, 1 decode, 2 full channel, 3 reserved.
- req_data  in  DATA_WIDTH  DATA_IN value.
- req_width  in  2  CODEWORD_WIDTH: 0 = 8b, 1 = 16b, 2 = 32b.
- req_noise  in  DATA_WIDTH  NOISE value.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready.
- rsp_data  out  DATA_WIDTH  captured data_out.
- rsp_num_errors  out  2  captured num_of_errors.
- rsp_timeout  out  1  job aborted by watchdog.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data, zero-extended.
- PENABLE  out  1  APB enable.
- PSEL  out  1  APB select.
- PWRITE  out  1  APB write; always 1 when PSEL = 1.
- data_out  in  DATA_WIDTH  ECC result.
- operation_done  in  1  ECC completion pulse.
- num_of_errors  in  2  ECC error count.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0 except req_ready = 1.
  - The width shadow-valid flag is cleared and the watchdog counter is set to 0.
  - Reset mid-job abandons the APB transfer immediately: PSEL and PENABLE are 0 on the next cycle, and no response is produced.
- Register offsets: CTRL +0x00, DATA_IN +0x04, CODEWORD_WIDTH +0x08, NOISE +0x0C.
- States: IDLE, SETUP, ACCESS, WAIT_DONE, RESP.
- IDLE:
  - req_ready = 1.
  - On handshake, latch the whole request into job registers, deassert req_ready and go to SETUP with write index 0.
  - req_op = 3 is accepted and sequenced as written; the ECC block defines the consequence.
- Write list, in order:
  1. DATA_IN
  2. CODEWORD_WIDTH, skipped when the shadow flag is valid and the shadow value equals the latched width.
  3. NOISE
  4. CTRL = {30'b0, op}
- SETUP: PSEL = 1, PENABLE = 0, PWRITE = 1, with PADDR and PWDATA for the current entry. Always one cycle, then ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1, with PADDR and PWDATA held.
  - No PREADY: the access completes in one cycle.
  - Next state is SETUP of the next entry, back-to-back, so PSEL stays high. After CTRL the next state is WAIT_DONE.
  - Each APB write takes exactly 2 cycles. A full job is 8 cycles from acceptance to entering WAIT_DONE, or 6 cycles when the width write is skipped.
  - Completing the CODEWORD_WIDTH access updates the shadow value and sets the shadow flag.
- WAIT_DONE:
  - PSEL = 0, PENABLE = 0; PADDR and PWDATA hold their last values.
  - The counter increments each cycle.
  - If operation_done = 1: capture data_out and num_of_errors, set rsp_timeout = 0, go to RESP.
  - Else if the counter reaches TIMEOUT_CYCLES - 1: set rsp_data = 0, rsp_num_errors = 0, rsp_timeout = 1, clear the shadow flag, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- operation_done outside WAIT_DONE is ignored.
- RESP:
  - rsp_valid = 1; rsp_* hold stable until rsp_ready.
  - On handshake, go to IDLE with rsp_valid = 0 on the next cycle. The counter is cleared on entering WAIT_DONE.
- Only one job is outstanding. req_ready = 0 from acceptance until the cycle after the response handshake.

Test Plan:
- Encode with rst released, req_op = 0, data = 0x000000A5, width = 0, noise = 0, rsp_ready = 1 → APB writes at 0x04 = 0xA5, 0x08 = 0, 0x0C = 0, 0x00 = 0, each SETUP then ACCESS with no idle cycles between them. The ECC model pulses done 3 cycles later with data_out = 0x5A → rsp_valid with rsp_data = 0x5A, rsp_timeout = 0.
- Second job with the same width = 0 → no write to 0x08; WAIT_DONE is entered 6 cycles after acceptance. A third job with width = 2 → the 0x08 = 2 write reappears.
- Decode job where the ECC model never asserts done, TIMEOUT_CYCLES = 64 → rsp_timeout = 1 and rsp_data = 0 exactly 64 cycles after entering WAIT_DONE. The next job rewrites CODEWORD_WIDTH.
- Response backpressure: hold rsp_ready = 0 for 10 cycles → rsp_valid stays 1, rsp_data stays stable and req_ready stays 0. A req_valid pulse during this window is not accepted.
- Reset asserted during ACCESS of the NOISE write → next cycle PSEL = 0, PENABLE = 0, req_ready = 1, no rsp_valid. The next job writes CODEWORD_WIDTH again.
- operation_done pulsed while in SETUP with num_of_errors = 2 → ignored. A later done with num_of_errors = 1 → rsp_num_errors = 1.
